load_store_unit: RTL and testbench

//  Sits between the execute stage and datamemory: turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WR_LO = 3'd3,
    S_WR_HI = 3'd4,
    S_RESP  = 3'd5
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // access size encoded as byte count minus one
  typedef logic [1:0] lsu_size_t;
  localparam lsu_size_t SZ_B = 2'd0;
  localparam lsu_size_t SZ_H = 2'd1;
  localparam lsu_size_t SZ_W = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: load extract/extend from {buf_hi,buf_lo} and store merge into the same
// two-word window, so split accesses fall out of the same shift.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] buf_lo_i,
  input  logic [31:0] buf_hi_i,
  input  logic [31:0] store_data_i,
  input  logic [1:0]  off_i,
  input  lsu_size_t   size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_data_o,
  output logic [31:0] wdata_lo_o,
  output logic [31:0] wdata_hi_o
);

  logic [63:0] window;
  logic [63:0] mask;
  logic [63:0] mask_sh;
  logic [63:0] data_sh;
  logic [63:0] merged;
  logic [31:0] shifted;
  logic [5:0]  sh_amt;

  assign sh_amt  = {1'b0, off_i, 3'b000};
  assign window  = {buf_hi_i, buf_lo_i};
  assign shifted = 32'(window >> sh_amt);

  always_comb begin
    unique case (size_i)
      SZ_B:    mask = 64'h0000_0000_0000_00FF;
      SZ_H:    mask = 64'h0000_0000_0000_FFFF;
      default: mask = 64'h0000_0000_FFFF_FFFF;
    endcase
  end

  always_comb begin
    unique case (size_i)
      SZ_B:    load_data_o = {{24{shifted[7] & ~unsigned_i}}, shifted[7:0]};
      SZ_H:    load_data_o = {{16{shifted[15] & ~unsigned_i}}, shifted[15:0]};
      default: load_data_o = shifted;
    endcase
  end

  assign mask_sh    = mask << sh_amt;
  assign data_sh    = {32'h0, store_data_i} << sh_amt;
  assign merged     = (window & ~mask_sh) | (data_sh & mask_sh);
  assign wdata_lo_o = merged[31:0];
  assign wdata_hi_o = merged[63:32];

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a word-wide memory without byte enables; sub-word stores are RMW.
// Define LSU_MISALIGN_EN to perform misaligned accesses (split into LO/HI words when needed).
//
// state   | meaning
// IDLE    | ready for a request
// RD_LO   | reading low (or only) word into buf_lo
// RD_HI   | reading high word of a split access into buf_hi
// WR_LO   | writing merged low word
// WR_HI   | writing merged high word of a split store
// RESP    | response held until rsp_ready
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DM_A_W   = 33,
  parameter int DM_WORDS = 4198
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              dm_re,
  output logic              dm_we,
  output logic [DM_A_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam logic [29:0] WORDS_L = 30'(DM_WORDS);

  lsu_state_e  state_q;
  logic        store_q, uns_q, split_q, err_q;
  lsu_size_t   size_q;
  logic [1:0]  off_q;
  logic [29:0] lo_q, hi_q;
  logic [31:0] wdata_q, buf_lo_q, buf_hi_q;

  lsu_size_t   dec_size;
  logic        dec_uns, dec_ill, dec_misal, dec_split, dec_oor, dec_err;
  logic [29:0] dec_lo, dec_hi;
  logic [31:0] load_data, wdata_lo, wdata_hi;

  always_comb begin
    dec_size = SZ_B;
    dec_uns  = 1'b0;
    dec_ill  = 1'b0;
    case (req_funct3)
      F3_B:    dec_size = SZ_B;
      F3_H:    dec_size = SZ_H;
      F3_W:    dec_size = SZ_W;
      F3_BU:   dec_uns  = 1'b1;
      F3_HU:   begin dec_size = SZ_H; dec_uns = 1'b1; end
      default: dec_ill  = 1'b1;
    endcase
    if (req_store && req_funct3 > F3_W) dec_ill = 1'b1;
  end

  assign dec_lo = req_addr[31:2];
  assign dec_hi = dec_lo + 30'd1;

`ifdef LSU_MISALIGN_EN
  assign dec_misal = 1'b0;
  assign dec_split = ({1'b0, req_addr[1:0]} + {1'b0, dec_size}) > 3'd3;
`else
  assign dec_misal = |(req_addr[1:0] & dec_size);
  assign dec_split = 1'b0;
`endif

  // the HI word of a split must be in range too, otherwise nothing is touched
  assign dec_oor = (dec_lo >= WORDS_L) | (dec_split & (dec_hi >= WORDS_L));
  assign dec_err = dec_ill | dec_misal | dec_oor;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      store_q  <= 1'b0;
      uns_q    <= 1'b0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= SZ_B;
      off_q    <= 2'b00;
      lo_q     <= '0;
      hi_q     <= '0;
      wdata_q  <= '0;
      buf_lo_q <= '0;
      buf_hi_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (req_valid) begin
          store_q <= req_store;
          uns_q   <= dec_uns;
          split_q <= dec_split;
          err_q   <= dec_err;
          size_q  <= dec_size;
          off_q   <= req_addr[1:0];
          lo_q    <= dec_lo;
          hi_q    <= dec_hi;
          wdata_q <= req_wdata;
          if (dec_err)                                         state_q <= S_RESP;
          else if (req_store && dec_size == SZ_W && !dec_split) state_q <= S_WR_LO;
          else                                                 state_q <= S_RD_LO;
        end
        S_RD_LO: begin
          buf_lo_q <= dm_rdata;
          if (split_q)      state_q <= S_RD_HI;
          else if (store_q) state_q <= S_WR_LO;
          else              state_q <= S_RESP;
        end
        S_RD_HI: begin
          buf_hi_q <= dm_rdata;
          state_q  <= store_q ? S_WR_LO : S_RESP;
        end
        S_WR_LO: state_q <= split_q ? S_WR_HI : S_RESP;
        S_WR_HI: state_q <= S_RESP;
        S_RESP:  if (rsp_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  lsu_align u_align (
    .buf_lo_i     (buf_lo_q),
    .buf_hi_i     (buf_hi_q),
    .store_data_i (wdata_q),
    .off_i        (off_q),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .load_data_o  (load_data),
    .wdata_lo_o   (wdata_lo),
    .wdata_hi_o   (wdata_hi)
  );

  always_comb begin
    dm_re    = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    case (state_q)
      S_RD_LO: begin dm_re = 1'b1; dm_addr = DM_A_W'(lo_q); end
      S_RD_HI: begin dm_re = 1'b1; dm_addr = DM_A_W'(hi_q); end
      S_WR_LO: begin dm_we = 1'b1; dm_addr = DM_A_W'(lo_q); dm_wdata = wdata_lo; end
      S_WR_HI: begin dm_we = 1'b1; dm_addr = DM_A_W'(hi_q); dm_wdata = wdata_hi; end
      default: ;
    endcase
  end

  assign req_ready = rst & (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid & ~err_q & ~store_q) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic against a byte-level
// reference memory. Honours LSU_MISALIGN_EN the same way the design does.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int DM_WORDS = 4198;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0, rsp_ready = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, dm_re, dm_we;
  logic [31:0] rsp_rdata, dm_wdata, dm_rdata;
  logic [32:0] dm_addr;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(32), .DM_A_W(33), .DM_WORDS(DM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  logic [31:0] mem     [DM_WORDS];
  logic [31:0] ref_mem [DM_WORDS];
  logic        pre_we = 1'b0;
  int          pre_idx = 0;
  logic [31:0] pre_val = '0;
  int          acc_cnt = 0;
  int          total = 0, bad = 0;
  logic [31:0] last_rd;
  logic        last_err;
  int          last_lat;

  function automatic logic [31:0] fill(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // datamemory: combinational read, write on posedge
  assign dm_rdata = (dm_addr < 33'(DM_WORDS)) ? mem[int'(dm_addr)] : 32'hDEAD_BEEF;

  initial begin
    for (int i = 0; i < DM_WORDS; i++) mem[i] = fill(i);
    forever begin
      @(posedge clk);
      if (dm_we && dm_addr < 33'(DM_WORDS)) mem[int'(dm_addr)] = dm_wdata;
      else if (pre_we) mem[pre_idx] = pre_val;
    end
  end

  always @(posedge clk) if (dm_re | dm_we) acc_cnt <= acc_cnt + 1;

  always @(negedge clk) chk("re_we_excl", 64'(dm_re & dm_we), 64'd0);

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_idx = idx; pre_val = val; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Reference: byte-addressed view of memory, updates ref_mem for stores.
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output bit er, output int lat);
    int nb;
    bit uns, ill, misal, split, oor;
    logic [31:0] w, wh, ba, v;
    nb = 1; uns = 0; ill = 0;
    case (f3)
      3'd0: nb = 1;
      3'd1: nb = 2;
      3'd2: nb = 4;
      3'd4: begin nb = 1; uns = 1; end
      3'd5: begin nb = 2; uns = 1; end
      default: ill = 1;
    endcase
    if (st && f3 > 3'd2) ill = 1;
    w  = a >> 2;
    wh = (w + 32'd1) & 32'h3FFF_FFFF;
    split = (int'(a[1:0]) + nb) > 4;
`ifdef LSU_MISALIGN_EN
    misal = 0;
`else
    misal = (int'(a[1:0]) % nb) != 0;
`endif
    oor = (w >= DM_WORDS) || (split && wh >= DM_WORDS);
    er  = ill || misal || oor;
    rd  = '0;
    lat = 1;
    if (er) return;
    if (!st) begin
      v = '0;
      for (int i = 0; i < nb; i++) begin
        ba = a + 32'(i);
        v  = v | (((ref_mem[ba >> 2] >> (8 * ba[1:0])) & 32'hFF) << (8 * i));
      end
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      rd  = v;
      lat = split ? 3 : 2;
    end else begin
      for (int i = 0; i < nb; i++) begin
        ba = a + 32'(i);
        ref_mem[ba >> 2][8*ba[1:0] +: 8] = wd[8*i +: 8];
      end
      lat = split ? 5 : (nb == 4 ? 2 : 3);
    end
  endtask

  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold);
    logic [31:0] erd, w;
    bit eer;
    int elat, waited, cyc, acc0;
    model(st, f3, a, wd, erd, eer, elat);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    waited = 0;
    while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
    chk("accept_timeout", 64'(waited >= 20), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    acc0 = acc_cnt;
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("latency", 64'(cyc), 64'(elat));
    chk("rsp_err", 64'(rsp_err), 64'(eer));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(erd));
    last_rd = rsp_rdata; last_err = rsp_err; last_lat = cyc;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_store = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom_range(0, 63); req_wdata = $urandom;
      @(posedge clk); #1;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rdata", 64'(rsp_rdata), 64'(erd));
      chk("hold_err", 64'(rsp_err), 64'(eer));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    if (eer) chk("err_no_access", 64'(acc_cnt - acc0), 64'd0);
    w = a >> 2;
    if (st && w < DM_WORDS) chk("mem_lo", 64'(mem[w]), 64'(ref_mem[w]));
    w = (w + 32'd1) & 32'h3FFF_FFFF;
    if (st && w < DM_WORDS) chk("mem_hi", 64'(mem[w]), 64'(ref_mem[w]));
  endtask

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;
    for (int i = 0; i < DM_WORDS; i++) ref_mem[i] = fill(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_dm_re", 64'(dm_re), 64'd0);
    chk("rst_dm_we", 64'(dm_we), 64'd0);
    chk("rst_dm_addr", 64'(dm_addr), 64'd0);
    chk("rst_dm_wdata", 64'(dm_wdata), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // reset while an SB is about to write back
    preload(3, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0D; req_wdata = 32'hAB;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rmw_wr_pending", 64'(dm_we), 64'd1);
    rst = 1'b0;
    #1;
    chk("abort_dm_we", 64'(dm_we), 64'd0);
    chk("abort_dm_re", 64'(dm_re), 64'd0);
    chk("abort_dm_addr", 64'(dm_addr), 64'd0);
    chk("abort_dm_wdata", 64'(dm_wdata), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    chk("abort_mem_kept", 64'(mem[3]), 64'h1122_3344);
    @(negedge clk); rst = 1'b1;

    preload(5, 32'h8000_00F0);
    do_req(0, 3'b000, 32'h14, 0, 0); chk("lb_val", 64'(last_rd), 64'hFFFF_FFF0);
    do_req(0, 3'b100, 32'h14, 0, 0); chk("lbu_val", 64'(last_rd), 64'h0000_00F0);
    do_req(0, 3'b001, 32'h16, 0, 0); chk("lh_val", 64'(last_rd), 64'hFFFF_8000);
    do_req(0, 3'b010, 32'h14, 0, 0); chk("lw_val", 64'(last_rd), 64'h8000_00F0);
    chk("lw_lat", 64'(last_lat), 64'd2);

    do_req(1, 3'b000, 32'h0D, 32'h5566_77AB, 0);
    chk("sb_word", 64'(mem[3]), 64'h1122_AB44);
    chk("sb_lat", 64'(last_lat), 64'd3);

    preload(8, 32'hDDCC_BBAA);
    preload(9, 32'h0000_00EE);
`ifdef LSU_MISALIGN_EN
    do_req(0, 3'b010, 32'h21, 0, 0);
    chk("mis_lw_val", 64'(last_rd), 64'hEEDD_CCBB);
    chk("mis_lw_lat", 64'(last_lat), 64'd3);
    do_req(1, 3'b010, 32'h23, 32'h0403_0201, 0);
    chk("mis_sw_w8", 64'(mem[8][31:24]), 64'h01);
    chk("mis_sw_w9", 64'(mem[9][23:0]), 64'h04_0302);
    chk("mis_sw_lat", 64'(last_lat), 64'd5);
`else
    do_req(0, 3'b010, 32'h21, 0, 0);
    chk("mis_lw_err", 64'(last_err), 64'd1);
    chk("mis_lw_rdata", 64'(last_rd), 64'd0);
`endif

    do_req(0, 3'b010, 32'(4198 * 4), 0, 0);     chk("oor_err", 64'(last_err), 64'd1);
    do_req(0, 3'b010, 32'(4197 * 4), 0, 0);     chk("last_word_ok", 64'(last_err), 64'd0);
    do_req(0, 3'b011, 32'h14, 0, 0);            chk("ill_load_err", 64'(last_err), 64'd1);
    do_req(1, 3'b101, 32'h14, 32'h1234, 0);     chk("ill_store_err", 64'(last_err), 64'd1);
    do_req(0, 3'b010, 32'(4197 * 4 + 2), 0, 0); chk("split_oor_err", 64'(last_err), 64'd1);

    do_req(0, 3'b010, 32'h14, 0, 5);
    chk("bp_val", 64'(last_rd), 64'h8000_00F0);
    do_req(0, 3'b000, 32'h14, 0, 0);

    for (int n = 0; n < 400; n++) begin
      st = 1'($urandom);
      r  = $urandom_range(0, 9);
      if (r == 0) f3 = 3'($urandom);
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'((DM_WORDS - 2 + $urandom_range(0, 3)) * 4) + 32'($urandom_range(0, 3));
      else if (r == 1) a = $urandom;
      else             a = 32'($urandom_range(0, 63));
      do_req(st, f3, a, $urandom, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
